// File: rtl/can_bit_timing.sv
// CAN bit-timing engine: TQ prescaler, SYNC/TSEG1/TSEG2 sequencing, hard sync and SJW-limited resync.
// Optional macro CAN_TRIPLE_SAMPLE_EN selects 2-of-3 majority sampling over the last three TSEG1 quanta.
module can_bit_timing #(
    parameter int BRP_W   = 6,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3,
    parameter int SJW_W   = 2,
    parameter int POS_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               hard_sync_en,
    input  logic               rx,
    output logic               tq_tick,
    output logic               bit_tick,
    output logic               sample_point,
    output logic               sampled_bit,
    output logic [1:0]         seg,
    output logic [POS_W-1:0]   tq_position,
    output logic               resync_done
);

    typedef enum logic [1:0] {SEG_SYNC = 2'd0, SEG_TSEG1 = 2'd1, SEG_TSEG2 = 2'd2} seg_t;

    logic [BRP_W-1:0]   r_cnt;
    logic [BRP_W-1:0]   r_brp_s;
    logic [TSEG1_W-1:0] r_tseg1_s;
    logic [TSEG2_W-1:0] r_tseg2_s;
    logic [SJW_W-1:0]   r_sjw_s;
    logic               r_en_q;
    seg_t               r_seg;
    seg_t               r_seg_nxt;
    logic [POS_W-1:0]   r_pos;
    logic [POS_W-1:0]   r_pos_nxt;
    logic [POS_W-1:0]   r_ext;
    logic [POS_W-1:0]   r_short;
    logic               r_synced;
    logic               r_rx_prev;
    logic               r_tq_tick;
    logic               r_bit_tick;
    logic               r_sp;
    logic               r_sampled;
    logic               r_resync;
`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0]         r_trip;
`endif

    logic               w_load;
    logic               w_new_bit;
    logic [BRP_W-1:0]   w_brp;
    logic [TSEG1_W-1:0] w_tseg1;
    logic [TSEG2_W-1:0] w_tseg2;
    logic [SJW_W-1:0]   w_sjw;
    logic [BRP_W-1:0]   w_cnt_nx;
    logic               w_tick_nx;
    seg_t               w_seg_cur;
    logic [POS_W-1:0]   w_pos_cur;
    logic [POS_W-1:0]   w_ext_cur;
    logic [POS_W-1:0]   w_short_cur;
    logic               w_synced_cur;
    logic [POS_W-1:0]   w_sjw1;
    logic [POS_W-1:0]   w_t1_end;
    logic [POS_W-1:0]   w_t2_end;
    logic [POS_W-1:0]   w_e1;
    logic [POS_W-1:0]   w_ext_new;
    logic [POS_W-1:0]   w_rem;
    logic [POS_W-1:0]   w_short_new;
    logic               w_edge;
    logic               w_hard;
    logic               w_sample;
    seg_t               w_seg_go;
    logic [POS_W-1:0]   w_pos_go;
    logic [POS_W-1:0]   w_ext_nx;
    logic [POS_W-1:0]   w_short_nx;
    logic               w_sp;
    logic               w_bt;
    logic               w_rs;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [POS_W-1:0] min_pos(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Prescaler lookahead and shadow selection; w_seg_cur is the TQ in progress during the next cycle
    always_comb begin
        w_load       = enable & ~r_en_q;
        w_new_bit    = w_load | (r_tq_tick & (r_seg_nxt == SEG_SYNC));
        w_brp        = w_new_bit ? brp   : r_brp_s;
        w_tseg1      = w_new_bit ? tseg1 : r_tseg1_s;
        w_tseg2      = w_new_bit ? tseg2 : r_tseg2_s;
        w_sjw        = w_new_bit ? sjw   : r_sjw_s;
        if (w_load || (r_cnt == r_brp_s)) begin
            w_cnt_nx = {BRP_W{1'b0}};
        end else begin
            w_cnt_nx = r_cnt + BRP_W'(1);
        end
        w_tick_nx    = enable & (w_cnt_nx == w_brp);
        w_seg_cur    = r_tq_tick ? r_seg_nxt : r_seg;
        w_pos_cur    = r_tq_tick ? r_pos_nxt : r_pos;
        w_ext_cur    = w_new_bit ? {POS_W{1'b0}} : r_ext;
        w_short_cur  = w_new_bit ? {POS_W{1'b0}} : r_short;
        w_synced_cur = w_new_bit ? 1'b0 : r_synced;
        w_sjw1       = POS_W'(w_sjw) + POS_W'(1);
        w_t1_end     = POS_W'(w_tseg1) + POS_W'(2) + w_ext_cur;
        w_t2_end     = w_t1_end + POS_W'(w_tseg2) + POS_W'(1) - w_short_cur;
        w_e1         = w_pos_cur - POS_W'(1);
        w_ext_new    = min_pos(w_e1, w_sjw1);
        w_rem        = (w_t2_end > w_pos_cur) ? (w_t2_end - w_pos_cur) : {POS_W{1'b0}};
        w_short_new  = min_pos(w_rem, w_sjw1);
        w_edge       = r_rx_prev & ~rx & ~w_synced_cur;
        w_hard       = w_edge & hard_sync_en;
`ifdef CAN_TRIPLE_SAMPLE_EN
        w_sample     = ((w_t1_end - POS_W'(1)) >= POS_W'(3)) ? maj3(r_trip[1], r_trip[0], rx) : rx;
`else
        w_sample     = rx;
`endif
    end

    // Segment transition for the TQ ending at the next tick, including hard sync and resync
    always_comb begin
        w_seg_go   = SEG_TSEG1;
        w_pos_go   = w_pos_cur + POS_W'(1);
        w_ext_nx   = w_ext_cur;
        w_short_nx = w_short_cur;
        w_sp       = 1'b0;
        w_bt       = 1'b0;
        w_rs       = 1'b0;
        if (w_hard) begin
            w_pos_go   = POS_W'(2);
            w_ext_nx   = {POS_W{1'b0}};
            w_short_nx = {POS_W{1'b0}};
            w_rs       = 1'b1;
        end else begin
            case (w_seg_cur)
                SEG_SYNC: begin
                    w_seg_go = SEG_TSEG1;
                end
                SEG_TSEG1: begin
                    if (w_edge) begin
                        w_ext_nx = w_ext_new;
                        w_rs     = 1'b1;
                    end else if (w_pos_cur >= w_t1_end) begin
                        w_sp     = 1'b1;
                        w_seg_go = SEG_TSEG2;
                    end else begin
                        w_seg_go = SEG_TSEG1;
                    end
                end
                SEG_TSEG2: begin
                    w_seg_go = SEG_TSEG2;
                    if (w_edge) begin
                        w_short_nx = w_short_new;
                        w_rs       = 1'b1;
                    end else begin
                        w_short_nx = w_short_cur;
                    end
                    if ((w_edge && (w_short_new >= w_rem)) || (w_pos_cur >= w_t2_end)) begin
                        w_bt     = 1'b1;
                        w_seg_go = SEG_SYNC;
                        w_pos_go = POS_W'(1);
                    end else begin
                        w_bt     = 1'b0;
                    end
                end
                default: begin
                    w_seg_go = SEG_SYNC;
                    w_pos_go = POS_W'(1);
                end
            endcase
        end
    end

    // Engine state, shadows and registered pulse outputs; enable low holds the idle state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0; r_brp_s <= '0; r_tseg1_s <= '0; r_tseg2_s <= '0; r_sjw_s <= '0;
            r_en_q <= 1'b0; r_seg <= SEG_SYNC; r_seg_nxt <= SEG_SYNC;
            r_pos <= POS_W'(1); r_pos_nxt <= POS_W'(1); r_ext <= '0; r_short <= '0;
            r_synced <= 1'b0; r_rx_prev <= 1'b1; r_tq_tick <= 1'b0; r_bit_tick <= 1'b0;
            r_sp <= 1'b0; r_sampled <= 1'b1; r_resync <= 1'b0;
`ifdef CAN_TRIPLE_SAMPLE_EN
            r_trip <= 2'b11;
`endif
        end else if (!enable) begin
            r_cnt <= '0; r_brp_s <= '0; r_tseg1_s <= '0; r_tseg2_s <= '0; r_sjw_s <= '0;
            r_en_q <= 1'b0; r_seg <= SEG_SYNC; r_seg_nxt <= SEG_SYNC;
            r_pos <= POS_W'(1); r_pos_nxt <= POS_W'(1); r_ext <= '0; r_short <= '0;
            r_synced <= 1'b0; r_rx_prev <= 1'b1; r_tq_tick <= 1'b0; r_bit_tick <= 1'b0;
            r_sp <= 1'b0; r_sampled <= 1'b1; r_resync <= 1'b0;
`ifdef CAN_TRIPLE_SAMPLE_EN
            r_trip <= 2'b11;
`endif
        end else begin
            r_en_q    <= 1'b1;
            r_cnt     <= w_cnt_nx;
            r_brp_s   <= w_brp;
            r_tseg1_s <= w_tseg1;
            r_tseg2_s <= w_tseg2;
            r_sjw_s   <= w_sjw;
            r_seg     <= w_seg_cur;
            r_pos     <= w_pos_cur;
            r_tq_tick <= w_tick_nx;
            if (w_tick_nx) begin
                r_seg_nxt  <= w_seg_go;
                r_pos_nxt  <= w_pos_go;
                r_ext      <= w_ext_nx;
                r_short    <= w_short_nx;
                r_synced   <= w_synced_cur | w_rs;
                r_rx_prev  <= rx;
                r_sp       <= w_sp;
                r_bit_tick <= w_bt;
                r_resync   <= w_rs;
                if (w_sp) begin
                    r_sampled <= w_sample;
                end else begin
                    r_sampled <= r_sampled;
                end
`ifdef CAN_TRIPLE_SAMPLE_EN
                if (w_seg_cur == SEG_TSEG1) begin
                    r_trip <= {r_trip[0], rx};
                end else begin
                    r_trip <= r_trip;
                end
`endif
            end else begin
                r_ext      <= w_ext_cur;
                r_short    <= w_short_cur;
                r_synced   <= w_synced_cur;
                r_sp       <= 1'b0;
                r_bit_tick <= 1'b0;
                r_resync   <= 1'b0;
            end
        end
    end

    assign tq_tick      = r_tq_tick;
    assign bit_tick     = r_bit_tick;
    assign sample_point = r_sp;
    assign sampled_bit  = r_sampled;
    assign seg          = r_seg;
    assign tq_position  = r_pos;
    assign resync_done  = r_resync;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: nominal timing, resync, hard sync, config shadowing, brp=0 and async reset.
module tb_can_bit_timing;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] brp = 6'd0;
    logic [3:0] tseg1 = 4'd0;
    logic [2:0] tseg2 = 3'd0;
    logic [1:0] sjw = 2'd0;
    logic       hard_sync_en = 1'b0;
    logic       rx = 1'b1;
    logic       tq_tick, bit_tick, sample_point, sampled_bit, resync_done;
    logic [1:0] seg;
    logic [4:0] tq_position;

    int n_checks = 0;
    int n_fail = 0;
    int pos_at [0:127];
    int seg_at [0:127];
    int smp_at [0:127];
    int tk_c [0:3];
    int sp_c [0:3];
    int bt_c [0:3];
    int rs_c [0:3];
    int n_tick, n_sp, n_bt, n_rs;

    can_bit_timing dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .brp(brp), .tseg1(tseg1), .tseg2(tseg2),
        .sjw(sjw), .hard_sync_en(hard_sync_en), .rx(rx), .tq_tick(tq_tick), .bit_tick(bit_tick),
        .sample_point(sample_point), .sampled_bit(sampled_bit), .seg(seg),
        .tq_position(tq_position), .resync_done(resync_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic start(input int b, input int t1, input int t2, input int s, input logic hs);
        @(negedge clk);
        enable = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        brp = 6'(b); tseg1 = 4'(t1); tseg2 = 3'(t2); sjw = 2'(s); hard_sync_en = hs;
        enable = 1'b1;
    endtask

    // cycle 0 is the first cycle after the enable-rise edge; rx falls / tseg2 changes at negedge of the given cycle
    task automatic record(input int ncyc, input int fall_c, input int chg_c, input int chg_v);
        n_tick = 0; n_sp = 0; n_bt = 0; n_rs = 0;
        for (int i = 0; i < 4; i++) begin
            tk_c[i] = -1; sp_c[i] = -1; bt_c[i] = -1; rs_c[i] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            pos_at[c] = int'(tq_position);
            seg_at[c] = int'(seg);
            smp_at[c] = int'(sampled_bit);
            if (tq_tick) begin if (n_tick < 4) tk_c[n_tick] = c; n_tick++; end
            if (sample_point) begin if (n_sp < 4) sp_c[n_sp] = c; n_sp++; end
            if (bit_tick) begin if (n_bt < 4) bt_c[n_bt] = c; n_bt++; end
            if (resync_done) begin if (n_rs < 4) rs_c[n_rs] = c; n_rs++; end
            if (c == fall_c) rx = 1'b0;
            if (c == chg_c) tseg2 = 3'(chg_v);
        end
    endtask

    initial begin
        #12;
        check("rst_tq_tick", int'(tq_tick), 0);
        check("rst_bit_tick", int'(bit_tick), 0);
        check("rst_sample_point", int'(sample_point), 0);
        check("rst_sampled_bit", int'(sampled_bit), 1);
        check("rst_seg", int'(seg), 0);
        check("rst_tq_position", int'(tq_position), 1);
        check("rst_resync_done", int'(resync_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal: 10 TQ of 4 clk per bit
        start(3, 5, 2, 0, 1'b0);
        record(90, -1, -1, 0);
        check("nom_tick0", tk_c[0], 3);
        check("nom_tick1", tk_c[1], 7);
        check("nom_ntick", n_tick, 22);
        check("nom_sp0", sp_c[0], 27);
        check("nom_sp1", sp_c[1], 67);
        check("nom_bt0", bt_c[0], 39);
        check("nom_bt1", bt_c[1], 79);
        check("nom_pos3", pos_at[3], 1);
        check("nom_pos36", pos_at[36], 10);
        check("nom_pos40", pos_at[40], 1);
        check("nom_seg2", seg_at[2], 0);
        check("nom_seg4", seg_at[4], 1);
        check("nom_seg30", seg_at[30], 2);
        check("nom_smp30", smp_at[30], 1);
        check("nom_nrs", n_rs, 0);

        // late edge at end of TQ4: TSEG1 extended by sjw+1=2
        start(3, 5, 2, 1, 1'b0);
        record(90, 12, -1, 0);
        check("late_rs0", rs_c[0], 15);
        check("late_nrs", n_rs, 1);
        check("late_sp0", sp_c[0], 35);
        check("late_bt0", bt_c[0], 47);
        check("late_sp1", sp_c[1], 75);
        check("late_bt1", bt_c[1], 87);
        check("late_smp30", smp_at[30], 1);
        check("late_smp36", smp_at[36], 0);
        check("late_pos44", pos_at[44], 12);

        // early edge at end of TQ8: TSEG2 shortened by 2, bit ends on that tick
        start(3, 5, 2, 1, 1'b0);
        record(80, 28, -1, 0);
        check("early_rs0", rs_c[0], 31);
        check("early_bt0", bt_c[0], 31);
        check("early_bt1", bt_c[1], 71);
        check("early_nbt", n_bt, 2);
        check("early_pos32", pos_at[32], 1);
        check("early_smp30", smp_at[30], 1);

        // hard sync at end of TQ8
        start(3, 5, 2, 0, 1'b1);
        record(80, 28, -1, 0);
        check("hs_rs0", rs_c[0], 31);
        check("hs_sp0", sp_c[0], 27);
        check("hs_sp1", sp_c[1], 55);
        check("hs_bt0", bt_c[0], 67);
        check("hs_pos32", pos_at[32], 2);
        check("hs_seg32", seg_at[32], 1);
        check("hs_smp60", smp_at[60], 0);

        // mid-bit tseg2 write takes effect on the following bit
        start(3, 5, 2, 0, 1'b0);
        record(100, -1, 9, 4);
        check("cfg_bt0", bt_c[0], 39);
        check("cfg_sp1", sp_c[1], 67);
        check("cfg_bt1", bt_c[1], 87);
        check("cfg_pos86", pos_at[86], 12);

        // brp=0: tick every clock, 4 TQ bit
        start(0, 1, 0, 0, 1'b0);
        record(20, -1, -1, 0);
        check("b0_ntick", n_tick, 20);
        check("b0_sp0", sp_c[0], 2);
        check("b0_bt0", bt_c[0], 3);
        check("b0_bt1", bt_c[1], 7);

        // async reset in TQ5, then restart from SYNC
        start(3, 5, 2, 0, 1'b0);
        record(18, -1, -1, 0);
        check("ar_pos_before", pos_at[17], 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pos", int'(tq_position), 1);
        check("ar_seg", int'(seg), 0);
        check("ar_tq_tick", int'(tq_tick), 0);
        check("ar_sampled", int'(sampled_bit), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        record(50, -1, -1, 0);
        check("ar_tick0", tk_c[0], 3);
        check("ar_sp0", sp_c[0], 27);
        check("ar_bt0", bt_c[0], 39);
        check("ar_pos0", pos_at[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
Parametrised CAN bit-timing engine and successor to the fixed-width TQ generator. It generates time quanta from the system clock and sequences each bit through SYNC, TSEG1 and TSEG2. It applies hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges, and emits the sample point, bit boundary and sampled bit value. It sits between the CPU-visible timing registers and the CAN bit-stream/protocol logic.

Parameters:
- BRP_W, 6: width of brp; TQ length is brp+1 clocks.
- TSEG1_W, 4: width of tseg1; TSEG1 length is tseg1+1 TQ.
- TSEG2_W, 3: width of tseg2; TSEG2 length is tseg2+1 TQ.
- SJW_W, 2: width of sjw; jump width is sjw+1 TQ.
- POS_W, 5: width of tq_position; must hold 1+2^TSEG1_W+2^TSEG2_W+2^SJW_W.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: run the timing engine; 0 holds the idle state.
- brp, in, BRP_W: baud rate prescaler minus 1.
- tseg1, in, TSEG1_W: Prop_Seg+Phase_Seg1 minus 1.
- tseg2, in, TSEG2_W: Phase_Seg2 minus 1.
- sjw, in, SJW_W: synchronisation jump width minus 1.
- hard_sync_en, in, 1: next edge performs hard sync (bus idle / SOF).
- rx, in, 1: CAN RX, already synchronised to clk.
- tq_tick, out, 1: 1-cycle pulse at the end of each TQ.
- bit_tick, out, 1: 1-cycle pulse at the end of each bit.
- sample_point, out, 1: 1-cycle pulse at the end of TSEG1.
- sampled_bit, out, 1: bit value, valid from the sample_point cycle until the next.
- seg, out, 2: current segment; 0 = SYNC, 1 = TSEG1, 2 = TSEG2.
- tq_position, out, POS_W: 1-based TQ index within the current bit.
- resync_done, out, 1: 1-cycle pulse when a resync or hard sync is applied.

Behaviour:
- Reset (rst_n=0, async): all pulse outputs 0, sampled_bit=1, seg=SYNC, tq_position=1, prescaler=0, rx history=1, config shadows=0.
- enable=0: same state as reset, held synchronously. On enable 0->1 the first TQ starts on the next clock.
- Prescaler: counts 0..brp_s. tq_tick is asserted (registered) in the cycle the count equals brp_s, then the count wraps to 0. With brp=0, tq_tick is high every cycle.
- Config shadow: brp/tseg1/tseg2/sjw are latched into *_s at each bit start (SYNC entry) and on enable rise. Writes made mid-bit take effect from the next bit.
- Segment sequencing happens only on tq_tick:
  - SYNC lasts 1 TQ, then TSEG1.
  - TSEG1 lasts tseg1_s+1+ext TQ, then TSEG2.
  - TSEG2 lasts tseg2_s+1-short TQ, then SYNC.
  - tq_position increments per TQ and returns to 1 on SYNC.
- sample_point and bit_tick coincide with the tq_tick that ends TSEG1 and TSEG2 respectively.
- Edge detection: rx is sampled on every tq_tick. An edge is prev_sample=1 and current sample=0. At most one sync (hard or resync) per bit; further edges in the same bit are ignored.
- Hard sync (hard_sync_en=1 and edge): the TQ just ended counts as SYNC.
  - Next TQ is TSEG1 with tq_position=2; ext=short=0.
  - No bit_tick and no sample_point is emitted for the aborted bit; resync_done pulses.
  - Hard sync takes priority over resync.
- Edge ending the SYNC TQ: no action (phase error 0).
- Resync, edge in TSEG1: e = tq_position-1 of the ended TQ; ext = min(e, sjw_s+1).
- Resync, edge in TSEG2: e = TSEG2 TQs remaining after the ended TQ; short = min(e, sjw_s+1).
  - If the remaining TQ count reaches 0, bit_tick fires on this same tq_tick and SYNC follows.
- An edge on the tq_tick that also ends TSEG1 is a TSEG1 edge: it extends TSEG1 and suppresses sample_point for this tick.
- Arithmetic: all counters are unsigned with no wrap. POS_W is sized so the maximum bit length (1+16+8+4=29 at defaults) never overflows.

Optional Feature:
Macro CAN_TRIPLE_SAMPLE_EN.
- Defined: rx is captured on the last three tq_ticks of TSEG1, and sampled_bit is their 2-of-3 majority. When tseg1_s+1+ext < 3 the block falls back to single sampling.
- Undefined: sampled_bit = rx captured at the sample_point tq_tick. No extra flops.

Test Plan:
- Nominal timing: brp=3, tseg1=5, tseg2=2, rx=1 -> tq_tick every 4 clk, 10 TQ/bit, bit_tick every 40 clk, sample_point 28 clk after SYNC start, tq_position cycles 1..10.
- Late edge: same config with sjw=1, rx falls so the edge is sampled at the end of TQ 4 -> ext=2, bit is 12 TQ, sample_point at the end of TQ 9, resync_done pulses once.
- Early edge: edge sampled at the end of TQ 8 (first TSEG2 TQ), sjw=1 -> short=2, bit_tick on that same tick, bit is 8 TQ.
- Hard sync: hard_sync_en=1, edge at the end of TQ 8 -> no bit_tick, next tq_position=2, sample_point 6 TQ (24 clk) later.
- Mid-bit config write: change tseg2 2->4 at TQ 3 -> current bit stays 10 TQ, next bit is 12 TQ.
- Async reset at TQ 5: assert rst_n=0 between clock edges -> outputs reset immediately, tq_position=1; after release, timing restarts from SYNC.
